// File: rtl/cansec_aes_seq.sv
// Sequencer for the CAN XL AES insertion stage: ciphertext pass, then tag pass, on an external AES-128 core.
// Optional AES-done watchdog is built only when `CANSEC_AES_TIMEOUT_EN` is defined.
module cansec_aes_seq #(
  parameter int TO_CYCLES = 255
) (
  input  logic         clk,
  input  logic         g_rst,
  input  logic         tx_sec,
  input  logic         sec_start,
  input  logic         tx_success,
  input  logic [127:0] pt_blk,
  input  logic [127:0] hdr_blk,
  input  logic [127:0] iv,
  output logic         aes_start,
  output logic [127:0] aes_in,
  input  logic [127:0] aes_out,
  input  logic         aes_done,
  output logic [127:0] dataout,
  output logic         done,
  output logic [127:0] dataout_combined,
  output logic         done_combined,
  output logic         sec_busy,
  output logic         sec_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC,
    S_WAIT_ENC,
    S_TAG,
    S_WAIT_TAG,
    S_HOLD
  } state_t;

  state_t       state;
  logic [127:0] hdr_r;

`ifdef CANSEC_AES_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0] to_cnt;
`endif

  // aes_in is loaded on the edge that enters ENC/TAG so the core sees it together with aes_start;
  // the ciphertext therefore lives in dataout and needs no separate copy.
  always_ff @(posedge clk) begin
    if (g_rst) begin
      state            <= S_IDLE;
      hdr_r            <= '0;
      aes_start        <= 1'b0;
      aes_in           <= '0;
      dataout          <= '0;
      done             <= 1'b0;
      dataout_combined <= '0;
      done_combined    <= 1'b0;
      sec_busy         <= 1'b0;
      sec_err          <= 1'b0;
`ifdef CANSEC_AES_TIMEOUT_EN
      to_cnt           <= '0;
`endif
    end else begin
      aes_start <= 1'b0;
      done      <= 1'b0;
      sec_err   <= 1'b0;
`ifdef CANSEC_AES_TIMEOUT_EN
      if (state == S_WAIT_ENC || state == S_WAIT_TAG) begin
        to_cnt <= to_cnt + 8'd1;
      end else begin
        to_cnt <= '0;
      end
`endif
      if (tx_success) begin
        state            <= S_IDLE;
        hdr_r            <= '0;
        aes_in           <= '0;
        dataout          <= '0;
        dataout_combined <= '0;
        done_combined    <= 1'b0;
        sec_busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sec_start && tx_sec) begin
              hdr_r     <= hdr_blk;
              aes_in    <= pt_blk ^ iv;
              aes_start <= 1'b1;
              sec_busy  <= 1'b1;
              state     <= S_ENC;
            end
          end
          S_ENC: begin
            state <= S_WAIT_ENC;
          end
          S_WAIT_ENC: begin
            if (aes_done) begin
              dataout   <= aes_out;
              done      <= 1'b1;
              aes_in    <= aes_out ^ hdr_r;
              aes_start <= 1'b1;
              state     <= S_TAG;
            end
`ifdef CANSEC_AES_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              sec_err          <= 1'b1;
              state            <= S_IDLE;
              hdr_r            <= '0;
              aes_in           <= '0;
              dataout          <= '0;
              dataout_combined <= '0;
              done_combined    <= 1'b0;
              sec_busy         <= 1'b0;
            end
`endif
          end
          S_TAG: begin
            state <= S_WAIT_TAG;
          end
          S_WAIT_TAG: begin
            if (aes_done) begin
              dataout_combined <= aes_out;
              done_combined    <= 1'b1;
              sec_busy         <= 1'b0;
              state            <= S_HOLD;
            end
`ifdef CANSEC_AES_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              sec_err          <= 1'b1;
              state            <= S_IDLE;
              hdr_r            <= '0;
              aes_in           <= '0;
              dataout          <= '0;
              dataout_combined <= '0;
              done_combined    <= 1'b0;
              sec_busy         <= 1'b0;
            end
`endif
          end
          S_HOLD: begin
            state <= S_HOLD;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  ap_to_range: assert property (@(posedge clk) (TO_CYCLES >= 1) && (TO_CYCLES <= 255));
  ap_start_one: assert property (@(posedge clk) disable iff (g_rst) aes_start |=> !aes_start);
  ap_done_one: assert property (@(posedge clk) disable iff (g_rst) done |=> !done);

endmodule

// File: tb/tb_cansec_aes_seq.sv
// Randomized scoreboard bench for cansec_aes_seq with a behavioural AES stand-in.
module tb_cansec_aes_seq;

  localparam int M_INC = 0, M_PASS = 1, M_KEY = 2, M_NEVER = 3;
  localparam int SQ_NORMAL = 0, SQ_ABORT = 1, SQ_START_WAIT = 2, SQ_RESET = 3, SQ_TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         g_rst = 1'b1;
  logic         tx_sec = 1'b0;
  logic         sec_start = 1'b0;
  logic         tx_success = 1'b0;
  logic [127:0] pt_blk = '0;
  logic [127:0] hdr_blk = '0;
  logic [127:0] iv = '0;
  logic         aes_start;
  logic [127:0] aes_in;
  logic [127:0] aes_out = '0;
  logic         aes_done = 1'b0;
  logic [127:0] dataout;
  logic         done;
  logic [127:0] dataout_combined;
  logic         done_combined;
  logic         sec_busy;
  logic         sec_err;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           amode = M_INC;
  int           alat = 10;
  logic [127:0] akey = '0;
  bit           allow_err = 1'b0;

  logic [127:0] exp_in[$];
  logic [127:0] exp_ct[$];
  logic [127:0] exp_tag[$];

  cansec_aes_seq #(.TO_CYCLES(20)) dut (
    .clk(clk), .g_rst(g_rst), .tx_sec(tx_sec), .sec_start(sec_start), .tx_success(tx_success),
    .pt_blk(pt_blk), .hdr_blk(hdr_blk), .iv(iv), .aes_start(aes_start), .aes_in(aes_in),
    .aes_out(aes_out), .aes_done(aes_done), .dataout(dataout), .done(done),
    .dataout_combined(dataout_combined), .done_combined(done_combined),
    .sec_busy(sec_busy), .sec_err(sec_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic logic [127:0] aes_f(input logic [127:0] x);
    logic [127:0] r;
    case (amode)
      M_INC:   r = x + 128'd1;
      M_PASS:  r = x;
      default: r = {x[94:0], x[127:95]} ^ akey;
    endcase
    return r;
  endfunction

  function automatic logic [399:0] outs_now();
    return {11'd0, aes_start, aes_in, dataout, done, dataout_combined, done_combined, sec_busy, sec_err};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // AES core stand-in: answers aes_f(aes_in) alat cycles after aes_start.
  initial begin
    bit           busy_m = 1'b0;
    int           wait_m = 0;
    logic [127:0] cap = '0;
    forever begin
      @(negedge clk);
      aes_done = 1'b0;
      if (busy_m) begin
        wait_m--;
        if (wait_m == 0) begin
          if (sec_busy) chk("aes_in_stable", aes_in, cap);
          aes_done = 1'b1;
          aes_out  = aes_f(cap);
          busy_m   = 1'b0;
        end
      end else if (aes_start && amode != M_NEVER) begin
        cap    = aes_in;
        wait_m = alat;
        busy_m = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin
    logic prev_done = 1'b0;
    logic prev_dc = 1'b0;
    forever begin
      @(negedge clk);
      if (!g_rst) begin
        if (aes_start) begin
          if (exp_in.size() == 0) bad("unexpected_aes_start");
          else chk("aes_in", aes_in, exp_in.pop_front());
        end
        if (done) begin
          chk("done_pulse", prev_done, 1'b0);
          if (exp_ct.size() == 0) bad("unexpected_done");
          else chk("dataout", dataout, exp_ct.pop_front());
        end
        if (done_combined && !prev_dc) begin
          if (exp_tag.size() == 0) bad("unexpected_done_combined");
          else chk("dataout_combined", dataout_combined, exp_tag.pop_front());
        end
        if (sec_err && !allow_err) bad("unexpected_sec_err");
      end
      prev_done = done;
      prev_dc   = done_combined;
    end
  end

  task automatic run_seq(input logic [127:0] p_pt, input logic [127:0] p_iv,
                         input logic [127:0] p_hdr, input int mode);
    logic [127:0] ct, tag;
    int t;
    ct  = aes_f(p_pt ^ p_iv);
    tag = aes_f(ct ^ p_hdr);
    exp_in.push_back(p_pt ^ p_iv);
    if (mode == SQ_NORMAL || mode == SQ_START_WAIT || mode == SQ_ABORT) begin
      exp_ct.push_back(ct);
      exp_in.push_back(ct ^ p_hdr);
    end
    if (mode == SQ_NORMAL || mode == SQ_START_WAIT) exp_tag.push_back(tag);

    tx_sec = 1'b1; sec_start = 1'b1; pt_blk = p_pt; iv = p_iv; hdr_blk = p_hdr;
    @(negedge clk);
    sec_start = 1'b0; pt_blk = rnd128(); iv = rnd128(); hdr_blk = rnd128();
    tx_sec = 1'($urandom_range(0, 1));
    chk("enc_start", aes_start, 1'b1);
    @(negedge clk);
    chk("busy_wait_enc", sec_busy, 1'b1);

    if (mode == SQ_START_WAIT) begin
      tx_sec = 1'b1; sec_start = 1'b1;
      @(negedge clk);
      sec_start = 1'b0;
    end
    if (mode == SQ_RESET) begin
      g_rst = 1'b1;
      @(negedge clk);
      g_rst = 1'b0;
      chk("sync_reset_clear", outs_now(), '0);
      repeat (alat + 5) @(negedge clk);
      return;
    end
`ifdef CANSEC_AES_TIMEOUT_EN
    if (mode == SQ_TIMEOUT) begin
      allow_err = 1'b1;
      t = 0;
      while (!sec_err && t < 60) begin
        @(negedge clk);
        t++;
      end
      chk("timeout_cycles", t, 20);
      chk("timeout_outs", outs_now(), 400'd1);
      @(negedge clk);
      allow_err = 1'b0;
      chk("timeout_idle", outs_now(), '0);
      return;
    end
`endif
    if (mode == SQ_ABORT) begin
      t = 0;
      while (!done && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!done) bad("abort_no_done");
      @(negedge clk);
      tx_success = 1'b1;
      @(negedge clk);
      tx_success = 1'b0;
      chk("abort_clear", outs_now(), '0);
      repeat (alat + 5) @(negedge clk);
      chk("abort_no_tag", done_combined, 1'b0);
      return;
    end

    t = 0;
    while (!done_combined && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!done_combined) bad("tag_never_done");
    tx_sec = 1'b1; sec_start = 1'b1;
    @(negedge clk);
    sec_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_done_combined", done_combined, 1'b1);
    chk("hold_dataout", dataout, ct);
    chk("hold_tag", dataout_combined, tag);
    chk("hold_not_busy", sec_busy, 1'b0);
    tx_success = 1'b1;
    @(negedge clk);
    tx_success = 1'b0;
    chk("tx_success_clear", outs_now(), '0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    g_rst = 1'b0;
    chk("reset_state", outs_now(), '0);

    amode = M_INC; alat = 10;
    run_seq(128'h00112233445566778899AABBCCDDEEFF, '0, '0, SQ_NORMAL);

    amode = M_PASS; alat = 4;
    run_seq(rnd128(), {128{1'b1}}, 128'h1, SQ_NORMAL);

    amode = M_INC; alat = 10;
    run_seq(rnd128(), rnd128(), rnd128(), SQ_ABORT);

    tx_sec = 1'b0; sec_start = 1'b1;
    @(negedge clk);
    sec_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("gated_idle", sec_busy, 1'b0);

    amode = M_KEY; akey = rnd128(); alat = 8;
    run_seq(rnd128(), rnd128(), rnd128(), SQ_START_WAIT);

    amode = M_INC; alat = 10;
    run_seq(rnd128(), rnd128(), rnd128(), SQ_RESET);
    run_seq(rnd128(), rnd128(), rnd128(), SQ_NORMAL);

`ifdef CANSEC_AES_TIMEOUT_EN
    amode = M_NEVER;
    run_seq(rnd128(), rnd128(), rnd128(), SQ_TIMEOUT);
`endif

    for (int i = 0; i < 16; i++) begin
      amode = M_KEY; akey = rnd128(); alat = $urandom_range(1, 12);
      run_seq(rnd128(), rnd128(), rnd128(), SQ_NORMAL);
    end

    repeat (5) @(negedge clk);
    chk("pending_in", exp_in.size(), 0);
    chk("pending_ct", exp_ct.size(), 0);
    chk("pending_tag", exp_tag.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
